// File: rtl/serial_link_pkg.sv
// Shared definitions for both ends of the single-wire serial frame link:
// state encodings, line/parity constants and the frame-length helper.
package serial_link_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic LINE_IDLE   = 1'b1;
  // Parity bit plus data bits must XOR to this value (even parity).
  localparam logic PARITY_EVEN = 1'b0;

  function automatic int unsigned frame_bits(input int unsigned width, input bit parity_en);
    return width + 32'd2 + (parity_en ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/serial_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops
// reset to RESET_VAL so the output starts at the line's idle level.
module serial_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start, WIDTH data bits LSB first, optional even
// parity (SERIAL_RX_PARITY_EN), stop; one-entry valid/ready output register.
module serial_frame_rx
  import serial_link_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             serial_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             frame_err_o,
`ifdef SERIAL_RX_PARITY_EN
  output logic             parity_err_o,
`endif
  output logic             overrun_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  logic             rx_line;
  logic             line_q;
  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift;
  logic             word_ok;
`ifdef SERIAL_RX_PARITY_EN
  logic             par_bad;
`endif

  serial_sync #(.RESET_VAL(LINE_IDLE)) u_sync (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .d     (serial_i),
    .q     (rx_line)
  );

  assign busy_o = (state != ST_IDLE);

`ifdef SERIAL_RX_PARITY_EN
  assign word_ok = rx_line && !par_bad;
`else
  assign word_ok = rx_line;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q      <= LINE_IDLE;
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      line_q      <= rx_line;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      // Handshake retires the word; a load in the STOP branch overrides this.
      if (valid_o && ready_i) valid_o <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (line_q && !rx_line) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= rx_line ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            shift <= (shift >> 1) | (WIDTH'(rx_line) << (WIDTH - 1));
            if (bit_cnt == BIT_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            par_bad <= ((^shift) ^ rx_line) != PARITY_EVEN;
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt         <= '0;
            state       <= ST_IDLE;
            frame_err_o <= !rx_line;
`ifdef SERIAL_RX_PARITY_EN
            parity_err_o <= par_bad;
`endif
            if (word_ok) begin
              if (!valid_o || ready_i) begin
                data_o  <= shift;
                valid_o <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (WIDTH=8, CLKS_PER_BIT=16); the parity
// scenario is compiled in when SERIAL_RX_PARITY_EN is defined.
module tb_serial_frame_rx;
  import serial_link_pkg::*;

  localparam int unsigned W   = 8;
  localparam int unsigned CPB = 16;
`ifdef SERIAL_RX_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif
  localparam int unsigned NB  = frame_bits(W, P == 1);
  localparam int unsigned LAT = 2 + CPB / 2 + (W + P + 1) * CPB + 1;
  localparam int unsigned FT  = NB * CPB;

  logic         clk;
  logic         rst_n;
  logic         serial;
  logic         ready;
  logic [W-1:0] data;
  logic         valid;
  logic         busy;
  logic         ferr;
  logic         ovr;
`ifdef SERIAL_RX_PARITY_EN
  logic         perr;
`endif

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;

  serial_frame_rx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .serial_i    (serial),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .busy_o      (busy),
    .frame_err_o (ferr),
`ifdef SERIAL_RX_PARITY_EN
    .parity_err_o(perr),
`endif
    .overrun_o   (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_frame(input logic [7:0] d, input logic stop);
`ifdef SERIAL_RX_PARITY_EN
    return {21'b0, stop, ^d, d, 1'b0};
`else
    return {22'b0, stop, d, 1'b0};
`endif
  endfunction

  task automatic send_bits(input logic [31:0] frame, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      serial = frame[i];
      tick(CPB);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    serial = 1'b1;
    ready  = 1'b0;
    tick(3);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data",  32'(data),  32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_ferr",  32'(ferr),  32'd0);
    check("rst_ovr",   32'(ovr),   32'd0);
    rst_n = 1'b1;
    tick(5);

    // Clean frame 0xA5 with consumer ready.
    ready = 1'b1;
    fork
      send_bits(mk_frame(8'hA5, 1'b1), NB);
      begin
        tick(LAT - 1);
        check("a5_early_valid", 32'(valid), 32'd0);
        tick(1);
        check("a5_valid", 32'(valid), 32'd1);
        check("a5_data",  32'(data),  32'hA5);
        check("a5_ferr",  32'(ferr),  32'd0);
        check("a5_ovr",   32'(ovr),   32'd0);
        tick(1);
        check("a5_consumed", 32'(valid), 32'd0);
      end
    join

    // Back-to-back 0x3C, 0xC3 with consumer stalled.
    ready = 1'b0;
    fork
      begin
        send_bits(mk_frame(8'h3C, 1'b1), NB);
        send_bits(mk_frame(8'hC3, 1'b1), NB);
      end
      begin
        tick(LAT);
        check("b2b_valid1", 32'(valid), 32'd1);
        check("b2b_data1",  32'(data),  32'h3C);
        tick(FT);
        check("b2b_ovr",       32'(ovr),   32'd1);
        check("b2b_data_kept", 32'(data),  32'h3C);
        check("b2b_valid2",    32'(valid), 32'd1);
        tick(1);
        check("b2b_ovr_once", 32'(ovr), 32'd0);
      end
    join
    ready = 1'b1;
    tick(1);
    check("b2b_drain", 32'(valid), 32'd0);

    // Stop bit forced low on 0xFF, then a clean 0x01.
    fork
      send_bits(mk_frame(8'hFF, 1'b0), NB);
      begin
        tick(LAT);
        check("ferr_pulse", 32'(ferr),  32'd1);
        check("ferr_valid", 32'(valid), 32'd0);
        tick(1);
        check("ferr_once",  32'(ferr),  32'd0);
      end
    join
    serial = 1'b1;
    tick(CPB);
    fork
      send_bits(mk_frame(8'h01, 1'b1), NB);
      begin
        tick(LAT);
        check("after_ferr_valid", 32'(valid), 32'd1);
        check("after_ferr_data",  32'(data),  32'h01);
      end
    join

    // 3-cycle low glitch on idle line.
    serial = 1'b0;
    tick(3);
    serial = 1'b1;
    tick(2);
    check("glitch_busy", 32'(busy), 32'd1);
    tick(10);
    check("glitch_idle",  32'(busy),  32'd0);
    check("glitch_valid", 32'(valid), 32'd0);
    check("glitch_ferr",  32'(ferr),  32'd0);

`ifdef SERIAL_RX_PARITY_EN
    // 0x07 has three ones: parity bit 0 is wrong, 1 is right.
    fork
      send_bits({21'b0, 1'b1, 1'b0, 8'h07, 1'b0}, NB);
      begin
        tick(LAT);
        check("par_bad_err",   32'(perr),  32'd1);
        check("par_bad_valid", 32'(valid), 32'd0);
      end
    join
    fork
      send_bits({21'b0, 1'b1, 1'b1, 8'h07, 1'b0}, NB);
      begin
        tick(LAT);
        check("par_ok_err",   32'(perr),  32'd0);
        check("par_ok_valid", 32'(valid), 32'd1);
        check("par_ok_data",  32'(data),  32'h07);
      end
    join
`endif

    // Reset asserted in the middle of data bit 4.
    fork
      send_bits(mk_frame(8'hAA, 1'b1), NB);
      begin
        tick(CPB + 4 * CPB + CPB / 2);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_data",  32'(data),  32'd0);
        check("midrst_busy",  32'(busy),  32'd0);
        check("midrst_ferr",  32'(ferr),  32'd0);
        check("midrst_ovr",   32'(ovr),   32'd0);
      end
    join
    tick(2);
    rst_n = 1'b1;
    tick(CPB);
    fork
      send_bits(mk_frame(8'h55, 1'b1), NB);
      begin
        tick(LAT - 1);
        check("post_rst_early", 32'(valid), 32'd0);
        tick(1);
        check("post_rst_valid", 32'(valid), 32'd1);
        check("post_rst_data",  32'(data),  32'h55);
      end
    join

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Receive end of the team's single-wire serial frame link: recovers WIDTH-bit words framed as start bit, data LSB first, optional even parity and stop bit, from an asynchronous line driven by the companion transmitter. It oversamples the line at CLKS_PER_BIT clocks per bit, checks framing, and presents each word on a one-entry valid/ready output register. It sits between the board-level serial pin and any core consuming WIDTH-wide data.

## Interface
- WIDTH, 8, data bits per frame; legal range is 1 to 32.
- CLKS_PER_BIT, 16, clk_i cycles per serial bit; must be at least 4 and even.
- clk_i  input  1  sole clock; all logic on the rising edge.
- rst_ni  input  1  reset, asynchronous and active-low.
- serial_i  input  1  asynchronous serial line; idle level is 1.
- data_o  output  WIDTH  received word; stable while valid_o=1.
- valid_o  output  1  data_o holds an unconsumed word.
- ready_i  input  1  consumer accepts the word when valid_o and ready_i are both 1 at a rising edge.
- busy_o  output  1  high in every state except IDLE.
- frame_err_o  output  1  one-cycle pulse when the stop bit is sampled as 0.
- overrun_o  output  1  one-cycle pulse when a good word is dropped because the buffer is full.
- parity_err_o  output  1  one-cycle pulse on parity mismatch; present only with the macro.

## Operation
- serial_i passes through a 2-flop synchronizer. Both flops reset to 1.
- Reset values: data_o=0, valid_o=0, busy_o=0, all error pulses 0, FSM in IDLE, bit and sample counters 0.
- IDLE: a 1→0 transition of the synchronized line enters START and clears the sample counter.
- START: after CLKS_PER_BIT/2 cycles, sample the line.
  - Sample 0: enter DATA.
  - Sample 1: treat as a glitch; return to IDLE with no error pulse.
- DATA: every CLKS_PER_BIT cycles, sample one bit into a shift register, LSB first. After bit WIDTH-1, go to PARITY if enabled, otherwise STOP.
- PARITY: after CLKS_PER_BIT cycles, sample the bit. The parity bit plus all data bits must have an even number of 1s.
- STOP: after CLKS_PER_BIT cycles, sample the line and always return to IDLE.
  - Sample 1: the word is good and is offered to the buffer.
  - Sample 0: pulse frame_err_o and discard the word.
- Parity error: pulse parity_err_o in the stop-sample cycle and discard the word. If both errors occur, pulse both.
- Buffer, good word offered:
  - valid_o=0: load data_o and set valid_o.
  - valid_o=1 with a handshake in the same cycle: load the new word; valid_o stays 1.
  - valid_o=1 with no handshake: pulse overrun_o and drop the new word; data_o is unchanged.
- A handshake with no new word clears valid_o on the next edge.
- ready_i is ignored while valid_o=0.
- rst_ni asserted mid-frame aborts the frame immediately; no partial word is ever presented.
- ready_i has no combinational path to any output.

## Timing
- Sample point: mid-bit, at CLKS_PER_BIT/2 + n·CLKS_PER_BIT cycles after the synchronized falling edge.
- Latency, from the pin falling edge to valid_o=1: 2 + CLKS_PER_BIT/2 + (WIDTH+P+1)·CLKS_PER_BIT + 1 cycles, where P=1 with parity and 0 without. Example: WIDTH=8, CLKS_PER_BIT=16, P=0 gives 155.
- Error pulses and overrun_o are asserted for exactly one cycle: the cycle after the stop sample.
- IDLE is re-entered in that same cycle, so back-to-back frames with a single stop bit are received without loss.
- Throughput is one word per frame time. A consumer holding ready_i=1 never sees an overrun.

## Configuration
- SERIAL_RX_PARITY_EN defined:
  - the PARITY state exists and the frame is WIDTH+3 bits;
  - parity_err_o port is present.
- SERIAL_RX_PARITY_EN not defined:
  - the frame is WIDTH+2 bits;
  - the PARITY state is not generated and the parity_err_o port does not exist.
- The companion transmitter is built with the same macro setting.

## Structure
- Shared package serial_link_pkg holds:
  - FSM state encodings: IDLE, START, DATA, PARITY, STOP;
  - idle line level constant;
  - parity polarity constant (even);
  - the frame-length function used by both link ends.
- The synchronizer is a separate sub-module, serial_sync: 2 flops, reset value parameterized, reset to 1 here.

## Test plan
All scenarios use WIDTH=8, CLKS_PER_BIT=16 and the macro off, except scenario 5.
- Clean frame 0xA5, ready_i=1 → data_o=0xA5 and valid_o=1 at cycle 155 after the pin edge, for one cycle; no error pulses.
- 0x3C then 0xC3 back-to-back, ready_i=0 → 0x3C held, overrun_o pulses once, data_o stays 0x3C. Raising ready_i then clears valid_o on the next edge.
- Stop bit forced to 0 on frame 0xFF → frame_err_o pulses once; valid_o stays 0. A following frame 0x01 is received correctly.
- 3-cycle low glitch on an idle line → FSM returns to IDLE; no valid, no error pulses.
- Macro on, frame 0x07 sent with parity bit 0 → parity_err_o pulses, word discarded. With parity bit 1 → word delivered.
- rst_ni pulsed low during data bit 4 → all outputs 0 immediately. The next clean frame 0x55 is delivered correctly.
